// File: rtl/output_act_ctrl_if.sv
// Bus bundle for the output activation controller: activation stream in,
// packed-word fifo read port out, plus flush/clear control and status.
interface output_act_ctrl_if #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16
) ();
  logic                    CLEAR_FIFO;
  logic                    FLUSH;
  logic [INPUT_WIDTH-1:0]  DATA_IN;
  logic                    DATA_VALID;
  logic                    DATA_READY;
  logic                    FIFO_RD_CMD;
  logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA;
  logic                    FIFO_EMPTY;
  logic                    FIFO_FULL;
  logic                    FLUSH_DONE;
  logic [COUNT_WIDTH-1:0]  WORD_COUNT;

  // Producer/consumer side (compute array + reader)
  modport master (
    output CLEAR_FIFO, FLUSH, DATA_IN, DATA_VALID, FIFO_RD_CMD,
    input  DATA_READY, FIFO_RD_DATA, FIFO_EMPTY, FIFO_FULL, FLUSH_DONE, WORD_COUNT
  );

  // Controller side
  modport slave (
    input  CLEAR_FIFO, FLUSH, DATA_IN, DATA_VALID, FIFO_RD_CMD,
    output DATA_READY, FIFO_RD_DATA, FIFO_EMPTY, FIFO_FULL, FLUSH_DONE, WORD_COUNT
  );
endinterface

// File: rtl/output_act_ctrl.sv
// Output activation controller: packs narrow activation beats (LSB first)
// into wide words, stages each finished word in a one-entry pending slot and
// pushes it into an internal fifo read by an external agent. FLUSH emits a
// zero-padded partial word; a rising edge on CLEAR_FIFO discards everything.
module output_act_ctrl #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  output_act_ctrl_if.slave bus
);
  localparam int N     = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_PACK  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic                    clr_prev_r;
  logic [1:0]              state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [OUTPUT_WIDTH-1:0] pack_r;
  logic [OUTPUT_WIDTH-1:0] pend_r;
  logic                    pend_v_r;
  logic [OUTPUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fill_r;
  logic [OUTPUT_WIDTH-1:0] rd_data_r;
  logic [COUNT_WIDTH-1:0]  word_count_r;
  logic                    flush_done_r;

  logic                    clr_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    ready_s;
  logic                    acc_s;
  logic                    wr_s;
  logic                    rd_s;
  logic                    pend_free_s;
  logic [OUTPUT_WIDTH-1:0] pack_ins_s;
  logic [1:0]              state_n_s;
  logic [IDX_W-1:0]        idx_n_s;
  logic [OUTPUT_WIDTH-1:0] pack_n_s;
  logic [OUTPUT_WIDTH-1:0] pend_n_s;
  logic                    pend_v_n_s;

  assign clr_s       = bus.CLEAR_FIFO & ~clr_prev_r;
  assign full_s      = (fill_r == CNT_FULL);
  assign empty_s     = (fill_r == {CNT_W{1'b0}});
  assign ready_s     = ~(pend_v_r & full_s) & (state_r == ST_PACK);
  assign acc_s       = bus.DATA_VALID & ready_s;
  assign wr_s        = pend_v_r & ~full_s;
  assign rd_s        = bus.FIFO_RD_CMD & ~empty_s;
  // The slot can take a new word if empty or being drained into the fifo now
  assign pend_free_s = ~pend_v_r | wr_s;

  assign bus.DATA_READY   = ready_s;
  assign bus.FIFO_RD_DATA = rd_data_r;
  assign bus.FIFO_EMPTY   = empty_s;
  assign bus.FIFO_FULL    = full_s;
  assign bus.FLUSH_DONE   = flush_done_r;
  assign bus.WORD_COUNT   = word_count_r;

  // Insert the incoming beat at the current lane; upper lanes are still zero
  always_comb begin
    pack_ins_s = pack_r;
    pack_ins_s[idx_r*INPUT_WIDTH +: INPUT_WIDTH] = bus.DATA_IN;
  end

  // Next-state logic for the packer, pending slot and flush sequencer
  always_comb begin
    state_n_s  = state_r;
    idx_n_s    = idx_r;
    pack_n_s   = pack_r;
    pend_n_s   = pend_r;
    if (wr_s) begin
      pend_v_n_s = 1'b0;
    end else begin
      pend_v_n_s = pend_v_r;
    end
    case (state_r)
      ST_PACK: begin
        if (acc_s) begin
          if (idx_r == IDX_LAST) begin
            pend_n_s   = pack_ins_s;
            pend_v_n_s = 1'b1;
            pack_n_s   = {OUTPUT_WIDTH{1'b0}};
            idx_n_s    = {IDX_W{1'b0}};
          end else begin
            pack_n_s = pack_ins_s;
            idx_n_s  = idx_r + IDX_W'(1);
          end
        end else begin
          pack_n_s = pack_r;
        end
        if (bus.FLUSH) begin
          state_n_s = ST_FLUSH;
        end else begin
          state_n_s = ST_PACK;
        end
      end
      ST_FLUSH: begin
        if (idx_r != {IDX_W{1'b0}}) begin
          // Partial word: lanes above idx are already zero, so it is pre-padded
          if (pend_free_s) begin
            pend_n_s   = pack_r;
            pend_v_n_s = 1'b1;
            pack_n_s   = {OUTPUT_WIDTH{1'b0}};
            idx_n_s    = {IDX_W{1'b0}};
          end else begin
            pend_n_s = pend_r;
          end
        end else if (!pend_v_r) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_n_s = ST_PACK;
      end
      default: begin
        state_n_s = ST_PACK;
      end
    endcase
  end

  // Remember CLEAR_FIFO so a held level produces only one clear pulse
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      clr_prev_r <= 1'b0;
    end else begin
      clr_prev_r <= bus.CLEAR_FIFO;
    end
  end

  // Control state, fifo pointers, read data and counters; clear acts like reset
  always_ff @(posedge CLK) begin
    if (!RESETN || clr_s) begin
      state_r      <= ST_PACK;
      idx_r        <= {IDX_W{1'b0}};
      pack_r       <= {OUTPUT_WIDTH{1'b0}};
      pend_r       <= {OUTPUT_WIDTH{1'b0}};
      pend_v_r     <= 1'b0;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fill_r       <= {CNT_W{1'b0}};
      rd_data_r    <= {OUTPUT_WIDTH{1'b0}};
      word_count_r <= {COUNT_WIDTH{1'b0}};
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      idx_r        <= idx_n_s;
      pack_r       <= pack_n_s;
      pend_r       <= pend_n_s;
      pend_v_r     <= pend_v_n_s;
      flush_done_r <= (state_n_s == ST_DONE);
      if (wr_s) begin
        wr_ptr_r     <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
        word_count_r <= word_count_r + COUNT_WIDTH'(1);
      end
      if (rd_s) begin
        rd_ptr_r  <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      case ({wr_s, rd_s})
        2'b10:   fill_r <= fill_r + CNT_W'(1);
        2'b01:   fill_r <= fill_r - CNT_W'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Fifo storage; contents need no reset since the pointers define validity
  always_ff @(posedge CLK) begin
    if (wr_s && !clr_s) begin
      mem_r[wr_ptr_r] <= pend_r;
    end
  end
endmodule

// File: tb/tb_output_act_ctrl.sv
// Randomized, scoreboard-checked bench for output_act_ctrl.
module tb_output_act_ctrl;
  logic clk;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  output_act_ctrl_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .COUNT_WIDTH(16)) bus ();

  output_act_ctrl #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32), .FIFO_DEPTH(64), .COUNT_WIDTH(16)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: byte stream of the current word, expected words in order
  logic [7:0]  cur_q [$];
  logic [31:0] exp_q [$];
  logic [15:0] wc_model = 16'd0;
  bit          flushing = 1'b0;
  bit          rd_go    = 1'b0;
  bit          clr_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void emit_word();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < cur_q.size(); i++) w[8*i +: 8] = cur_q[i];
    exp_q.push_back(w);
    cur_q.delete();
    wc_model = wc_model + 16'd1;
  endfunction

  // Model: evaluates what the next clock edge will do, from stable inputs
  always @(negedge clk) begin
    if (!resetn || (bus.CLEAR_FIFO && !clr_prev)) begin
      cur_q.delete();
      exp_q.delete();
      wc_model = 16'd0;
      flushing = 1'b0;
      rd_go    = 1'b0;
    end else begin
      rd_go = bus.FIFO_RD_CMD && !bus.FIFO_EMPTY;
      if (bus.DATA_VALID && bus.DATA_READY) begin
        cur_q.push_back(bus.DATA_IN);
        if (cur_q.size() == 4) emit_word();
      end
      if (bus.FLUSH && !flushing) begin
        if (cur_q.size() != 0) emit_word();
        flushing = 1'b1;
      end
      if (bus.FLUSH_DONE) flushing = 1'b0;
    end
    clr_prev = resetn ? bus.CLEAR_FIFO : 1'b0;
  end

  // Monitor: every accepted read must present the oldest expected word
  always @(posedge clk) begin
    #2;
    if (rd_go) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_data: got %h expected no read data", bus.FIFO_RD_DATA);
      end else begin
        chk("rd_data", bus.FIFO_RD_DATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.DATA_VALID = 1'b0; bus.FLUSH = 1'b0; bus.FIFO_RD_CMD = 1'b0;
    bus.CLEAR_FIFO = 1'b0; bus.DATA_IN = 8'd0;
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    bus.DATA_IN = b;
    bus.DATA_VALID = 1'b1;
    @(negedge clk);
    while (!bus.DATA_READY && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_n(input int n);
    bus.FIFO_RD_CMD = 1'b1;
    cyc(n);
    bus.FIFO_RD_CMD = 1'b0;
    cyc(2);
  endtask

  task automatic count_done(input int win, output int pulses);
    pulses = 0;
    repeat (win) begin
      @(posedge clk);
      #1;
      if (bus.FLUSH_DONE) pulses++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.DATA_READY), 32'd1);
    chk({tag, "_empty"}, 32'(bus.FIFO_EMPTY), 32'd1);
    chk({tag, "_full"},  32'(bus.FIFO_FULL), 32'd0);
    chk({tag, "_rddata"}, bus.FIFO_RD_DATA, 32'd0);
    chk({tag, "_fdone"}, 32'(bus.FLUSH_DONE), 32'd0);
    chk({tag, "_wcount"}, 32'(bus.WORD_COUNT), 32'd0);
  endtask

  initial begin
    int p;
    int k;
    do_reset();
    chk_reset_outputs("reset");

    // 1: one full word, empty falls two cycles after the last beat
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    bus.DATA_VALID = 1'b0;
    chk("t1_empty_t1", 32'(bus.FIFO_EMPTY), 32'd1);
    cyc(1);
    chk("t1_empty_t2", 32'(bus.FIFO_EMPTY), 32'd0);
    chk("t1_wcount", 32'(bus.WORD_COUNT), 32'd1);
    read_n(1);
    chk("t1_rd_direct", bus.FIFO_RD_DATA, 32'h44332211);

    // 2: partial word flush, then flush with nothing buffered
    do_reset();
    send(8'hAA); send(8'hBB); send(8'hCC);
    bus.DATA_VALID = 1'b0;
    bus.FLUSH = 1'b1; cyc(1); bus.FLUSH = 1'b0;
    count_done(30, p);
    chk("t2_done_pulses", 32'(p), 32'd1);
    chk("t2_wcount", 32'(bus.WORD_COUNT), 32'd1);
    read_n(1);
    chk("t2_rd_direct", bus.FIFO_RD_DATA, 32'h00CCBBAA);
    bus.FLUSH = 1'b1; cyc(1); bus.FLUSH = 1'b0;
    chk("t2_idle_done_c1", 32'(bus.FLUSH_DONE), 32'd0);
    cyc(1);
    chk("t2_idle_done_c2", 32'(bus.FLUSH_DONE), 32'd1);
    cyc(1);
    chk("t2_idle_done_c3", 32'(bus.FLUSH_DONE), 32'd0);
    chk("t2_idle_wcount", 32'(bus.WORD_COUNT), 32'd1);
    chk("t2_idle_empty", 32'(bus.FIFO_EMPTY), 32'd1);

    // 3: fill fifo plus pending slot, then drain in order
    do_reset();
    for (int i = 0; i < 65 * 4; i++) send(8'($urandom));
    bus.DATA_VALID = 1'b0;
    cyc(3);
    chk("t3_full", 32'(bus.FIFO_FULL), 32'd1);
    chk("t3_ready", 32'(bus.DATA_READY), 32'd0);
    chk("t3_wcount_full", 32'(bus.WORD_COUNT), 32'd64);
    read_n(65);
    chk("t3_ready_back", 32'(bus.DATA_READY), 32'd1);
    chk("t3_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("t3_wcount", 32'(bus.WORD_COUNT), 32'd65);
    chk("t3_all_read", 32'(exp_q.size()), 32'd0);

    // 4: flush together with the word-completing beat
    do_reset();
    send(8'h11); send(8'h22); send(8'h33);
    bus.DATA_IN = 8'h44; bus.FLUSH = 1'b1;
    cyc(1);
    bus.DATA_VALID = 1'b0; bus.FLUSH = 1'b0;
    count_done(20, p);
    chk("t4_done_pulses", 32'(p), 32'd1);
    chk("t4_wcount", 32'(bus.WORD_COUNT), 32'd1);
    read_n(1);
    chk("t4_rd_direct", bus.FIFO_RD_DATA, 32'h44332211);
    chk("t4_no_extra", 32'(bus.FIFO_EMPTY), 32'd1);

    // 5: held clear acts once; beats sent while still held survive
    do_reset();
    for (int i = 0; i < 12; i++) send(8'($urandom));
    send(8'h01); send(8'h02);
    bus.DATA_VALID = 1'b0;
    cyc(3);
    chk("t5_pre_wcount", 32'(bus.WORD_COUNT), 32'd3);
    bus.CLEAR_FIFO = 1'b1;
    cyc(2);
    chk("t5_clr_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("t5_clr_wcount", 32'(bus.WORD_COUNT), 32'd0);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    bus.DATA_VALID = 1'b0;
    cyc(4);
    bus.CLEAR_FIFO = 1'b0;
    cyc(1);
    chk("t5_post_wcount", 32'(bus.WORD_COUNT), 32'd1);
    read_n(1);
    chk("t5_rd_direct", bus.FIFO_RD_DATA, 32'h08070605);

    // 6: reset while flushing
    do_reset();
    send(8'h01); send(8'h02);
    bus.DATA_VALID = 1'b0;
    bus.FLUSH = 1'b1; cyc(1); bus.FLUSH = 1'b0;
    resetn = 1'b0; cyc(1); resetn = 1'b1;
    chk_reset_outputs("t6");
    count_done(20, p);
    chk("t6_no_done", 32'(p), 32'd0);
    chk("t6_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("t6_wcount", 32'(bus.WORD_COUNT), 32'd0);

    // 7: random traffic with backpressure, flushes and clears
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bus.DATA_VALID  = ($urandom_range(0, 99) < 70);
      bus.DATA_IN     = 8'($urandom);
      bus.FIFO_RD_CMD = ($urandom_range(0, 99) < 35);
      bus.FLUSH       = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) bus.CLEAR_FIFO = ~bus.CLEAR_FIFO;
      cyc(1);
    end
    bus.DATA_VALID = 1'b0; bus.FLUSH = 1'b0; bus.CLEAR_FIFO = 1'b0;
    read_n(100);
    bus.FLUSH = 1'b1; cyc(1); bus.FLUSH = 1'b0;
    cyc(20);
    read_n(10);
    k = 0;
    while (!bus.FIFO_EMPTY && k < 200) begin
      read_n(1);
      k++;
    end
    chk("rand_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("rand_wcount", 32'(bus.WORD_COUNT), 32'(wc_model));
    chk("rand_all_read", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
